vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares the single-port video RAM (one SPRAM, 13-bit word address, 16-bit data, one-cycle read latency) between the display scan-out engine and the CPU. The display gets priority, with a starvation guard so the CPU is never locked out. A one-entry posted-write buffer lets CPU stores complete without waiting for a free slot. The block sits between the display/CPU buses and the VRAM macro, and replaces the fixed pixel-read-wins steering.

## Interface
- STARVE_LIMIT, 4: consecutive display grants allowed while CPU side is pending before the CPU side is forced a slot (1..15)
- clk  in  1  system clock, all logic rising-edge
- resetn  in  1  asynchronous, active-low reset
- d_req  in  1  display read request (level)
- d_addr  in  13  display word address
- d_gnt  out  1  display request granted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid (registered)
- d_rdata  out  16  display read data
- c_req  in  1  CPU request (level, held until c_ready)
- c_we  in  1  1 = write, 0 = read
- c_addr  in  13  CPU word address
- c_wdata  in  16  CPU write data
- c_ready  out  1  CPU request accepted this cycle (combinational)
- c_rvalid  out  1  c_rdata valid (registered)
- c_rdata  out  16  CPU read data
- m_addr  out  14  RAM address, {1'b0, 13-bit addr}
- m_din  out  16  RAM write data, 0 when not writing
- m_wren  out  1  RAM write enable
- m_dout  in  16  RAM read data, valid the cycle after address

## Operation
- One RAM slot per cycle. Owners are DISP (display read), WBUF (drain posted write), CRD (CPU read), or NONE.
- CPU side is pending when wbuf_valid is set, or when c_req && !c_we.
- Arbitration each cycle:
  - Forced CPU slot: if starve_cnt == STARVE_LIMIT and the CPU side is pending, the CPU side wins.
  - Otherwise, if d_req, DISP wins.
  - Otherwise the CPU side wins if pending.
- Within the CPU side, WBUF always beats CRD.
- CRD is granted only when wbuf_valid == 0. A read never passes a buffered write, which keeps ordering strict.
- starve_cnt (4 bits):
  - +1 on a DISP grant while the CPU side is pending.
  - Cleared on any WBUF or CRD grant, and cleared when the CPU side is not pending.
  - Saturates at STARVE_LIMIT.
- Write acceptance: c_ready = 1 for c_req && c_we when wbuf_valid == 0, or when WBUF is granted this cycle. The next edge loads the buffer (addr, data) and sets wbuf_valid. The RAM is not written in the accept cycle unless that cycle is the drain.
- Read acceptance: c_ready = 1 for c_req && !c_we exactly when CRD is granted.
- RAM drive:
  - DISP: m_addr = {0,d_addr}, m_wren = 0.
  - WBUF: m_addr = {0,wbuf_addr}, m_din = wbuf_data, m_wren = 1; wbuf_valid clears at the edge unless a new write is accepted in the same cycle.
  - CRD: m_addr = {0,c_addr}, m_wren = 0.
  - NONE: m_addr = 0, m_din = 0, m_wren = 0.
- Return tag register rtag ∈ {NONE, DISP, CRD} records the owner of each read slot.
  - Next cycle: rtag = DISP gives d_rvalid = 1 and d_rdata = m_dout; rtag = CRD gives c_rvalid = 1 and c_rdata = m_dout.
  - The idle return port's rdata reads 0.
- d_gnt = 1 only when DISP is granted. A display request that loses arbitration is held by the requester.

## Timing
- Reset (asynchronous assert, synchronous deassert by clk): d_gnt, d_rvalid, c_ready, c_rvalid, m_wren = 0; d_rdata, c_rdata, m_addr, m_din = 0; wbuf_valid = 0; starve_cnt = 0; rtag = NONE.
- Reset mid-operation discards a buffered write and any in-flight read return; no rvalid follows.
- Grant and c_ready are combinational in cycle N. Read data is valid in cycle N+1 for exactly one cycle.
- Throughput: one access per cycle. Continuous d_req with a pending CPU side yields STARVE_LIMIT display slots, then one CPU slot, repeating.
- A write in the accept cycle is visible to a CPU read only after the drain. The earliest read grant is the cycle after the drain, so read-after-write returns the new data.
- Simultaneous write accept and drain in the same cycle is legal: the buffer stays valid with the new contents.

## Test plan
- Display only: d_req = 1 at addr 0x0000..0x0003 each cycle → d_gnt = 1 every cycle; d_rvalid one cycle later with RAM contents; c_ready = 0.
- Posted write, no contention: c_req = 1, c_we = 1, addr 0x1ABC, data 0xBEEF → c_ready = 1 the same cycle; m_wren = 1 with m_addr = 0x1ABC the next cycle; a later read of 0x1ABC gives c_rvalid with 0xBEEF.
- Starvation guard (STARVE_LIMIT = 4): d_req held high with a pending CPU read at 0x0010 → 4 DISP grants, then CRD (c_ready = 1, d_gnt = 0), then DISP resumes; c_rvalid one cycle after CRD.
- Read-after-write ordering: write 0x0005 = 0x1234, then immediately read 0x0005 while d_req = 1 → the read is not granted before the WBUF drain; the returned c_rdata = 0x1234.
- Back-to-back writes: two writes on consecutive cycles with d_req = 0 → both c_ready = 1; the second accept coincides with the first drain; two m_wren pulses with the correct addr/data.
- Async reset mid-read: resetn low in the cycle after a CRD grant → c_rvalid stays 0; all outputs are 0 while resetn = 0; after release, the first request behaves as from power-up.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles the display port, CPU port and VRAM macro port of
// the VRAM arbiter.
//   display : d_req/d_addr in, d_gnt out, d_rvalid/d_rdata out
//   cpu     : c_req/c_we/c_addr/c_wdata in, c_ready out, c_rvalid/c_rdata out
//   ram     : m_addr/m_din/m_wren out, m_dout in (one-cycle read latency)
// slave  = arbiter side, master = requesters + RAM side.
interface vram_arbiter_if;
  logic        d_req;
  logic [12:0] d_addr;
  logic        d_gnt;
  logic        d_rvalid;
  logic [15:0] d_rdata;
  logic        c_req;
  logic        c_we;
  logic [12:0] c_addr;
  logic [15:0] c_wdata;
  logic        c_ready;
  logic        c_rvalid;
  logic [15:0] c_rdata;
  logic [13:0] m_addr;
  logic [15:0] m_din;
  logic        m_wren;
  logic [15:0] m_dout;

  modport slave (
    input  d_req, d_addr, c_req, c_we, c_addr, c_wdata, m_dout,
    output d_gnt, d_rvalid, d_rdata, c_ready, c_rvalid, c_rdata,
           m_addr, m_din, m_wren
  );

  modport master (
    output d_req, d_addr, c_req, c_we, c_addr, c_wdata, m_dout,
    input  d_gnt, d_rvalid, d_rdata, c_ready, c_rvalid, c_rdata,
           m_addr, m_din, m_wren
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port VRAM between display scan-out and CPU.
// Display reads have priority; after STARVE_LIMIT consecutive display grants
// with the CPU side waiting, the CPU side is forced one slot. CPU writes are
// posted into a one-entry buffer and drained in a later slot; CPU reads wait
// until that buffer is empty so they always observe prior writes.
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : display / CPU / RAM signals (vram_arbiter_if.slave)
module vram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           resetn,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_WBUF, OWN_CRD} own_e;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_CRD} tag_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        wbuf_valid_q, wbuf_valid_d;
  logic [12:0] wbuf_addr_q;
  logic [15:0] wbuf_data_q;
  logic [3:0]  starve_q, starve_d;
  tag_e        rtag_q, rtag_d;
  own_e        own;
  logic        cpu_pend;
  logic        wr_acc;

  // Slot owner. Grants are forced off while reset is asserted so the
  // combinational outputs read 0 during reset as well.
  always_comb begin
    cpu_pend = wbuf_valid_q | (bus.c_req & ~bus.c_we);
    own      = OWN_NONE;
    if (!resetn)
      own = OWN_NONE;
    else if (cpu_pend && (starve_q == LIMIT || !bus.d_req))
      own = wbuf_valid_q ? OWN_WBUF : OWN_CRD;
    else if (bus.d_req)
      own = OWN_DISP;
  end

  // A write is accepted into an empty buffer, or into the buffer being
  // drained this cycle (load and drain at the same edge).
  assign wr_acc = resetn & bus.c_req & bus.c_we & (~wbuf_valid_q | (own == OWN_WBUF));

  assign bus.d_gnt   = (own == OWN_DISP);
  assign bus.c_ready = wr_acc | (bus.c_req & ~bus.c_we & (own == OWN_CRD));

  always_comb begin
    bus.m_addr = '0;
    bus.m_din  = '0;
    bus.m_wren = 1'b0;
    case (own)
      OWN_DISP: bus.m_addr = {1'b0, bus.d_addr};
      OWN_WBUF: begin
        bus.m_addr = {1'b0, wbuf_addr_q};
        bus.m_din  = wbuf_data_q;
        bus.m_wren = 1'b1;
      end
      OWN_CRD:  bus.m_addr = {1'b0, bus.c_addr};
      default:  ;
    endcase
  end

  always_comb begin
    wbuf_valid_d = wbuf_valid_q;
    if (wr_acc)
      wbuf_valid_d = 1'b1;
    else if (own == OWN_WBUF)
      wbuf_valid_d = 1'b0;

    starve_d = starve_q;
    if (own == OWN_WBUF || own == OWN_CRD || !cpu_pend)
      starve_d = '0;
    else if (own == OWN_DISP && starve_q != LIMIT)
      starve_d = starve_q + 4'd1;

    case (own)
      OWN_DISP: rtag_d = TAG_DISP;
      OWN_CRD:  rtag_d = TAG_CRD;
      default:  rtag_d = TAG_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wbuf_valid_q <= 1'b0;
      wbuf_addr_q  <= '0;
      wbuf_data_q  <= '0;
      starve_q     <= '0;
      rtag_q       <= TAG_NONE;
    end else begin
      wbuf_valid_q <= wbuf_valid_d;
      if (wr_acc) begin
        wbuf_addr_q <= bus.c_addr;
        wbuf_data_q <= bus.c_wdata;
      end
      starve_q <= starve_d;
      rtag_q   <= rtag_d;
    end
  end

  // The tag says which port owns the RAM data returning this cycle.
  assign bus.d_rvalid = (rtag_q == TAG_DISP);
  assign bus.c_rvalid = (rtag_q == TAG_CRD);
  assign bus.d_rdata  = bus.d_rvalid ? bus.m_dout : 16'h0000;
  assign bus.c_rdata  = bus.c_rvalid ? bus.m_dout : 16'h0000;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  vram_arbiter_if bus ();

  vram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [12:0] a);
    return 16'hA000 | {3'b000, a};
  endfunction

  // VRAM macro: synchronous write, one-cycle registered read.
  logic [15:0] mem [0:8191];
  logic        ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 8192; i++) mem[i] <= init_val(13'(i));
      ram_ready  <= 1'b1;
      bus.m_dout <= 16'h0000;
    end else begin
      if (bus.m_wren) mem[bus.m_addr[12:0]] <= bus.m_din;
      bus.m_dout <= mem[bus.m_addr[12:0]];
    end
  end

  task automatic idle_inputs();
    bus.d_req = 1'b0; bus.d_addr = '0;
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    // Requests are driven during reset; every output must still read 0.
    resetn = 1'b0;
    bus.d_req = 1'b1; bus.d_addr = 13'h0007;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 13'h0009; bus.c_wdata = 16'hFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({bus.d_gnt, bus.c_ready, bus.d_rvalid, bus.c_rvalid, bus.m_wren} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 00000",
        {bus.d_gnt, bus.c_ready, bus.d_rvalid, bus.c_rvalid, bus.m_wren});
    end
    checks++;
    if ({bus.d_rdata, bus.c_rdata, bus.m_addr, bus.m_din} !== 62'h0) begin
      failures++; $display("FAIL reset_data: got %h expected 0",
        {bus.d_rdata, bus.c_rdata, bus.m_addr, bus.m_din});
    end
    idle_inputs();
    resetn = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({bus.d_gnt, bus.c_ready, bus.m_wren, bus.m_addr} !== 17'h0) begin
      failures++; $display("FAIL idle_after_reset: got %h expected 0",
        {bus.d_gnt, bus.c_ready, bus.m_wren, bus.m_addr});
    end
  endtask

  task automatic test_display_only();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.d_req  = (i < 4);
      bus.d_addr = 13'(i);
      #1;
      if (i < 4) begin
        chk("disp_gnt", {31'b0, bus.d_gnt}, 32'd1);
        chk("disp_maddr", {18'b0, bus.m_addr}, 32'(i));
        chk("disp_cready", {31'b0, bus.c_ready}, 32'd0);
      end
      if (i > 0) begin
        chk("disp_rvalid", {31'b0, bus.d_rvalid}, 32'd1);
        chk("disp_rdata", {16'b0, bus.d_rdata}, {16'b0, init_val(13'(i - 1))});
      end
    end
    idle_inputs();
  endtask

  task automatic test_posted_write();
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 13'h1ABC; bus.c_wdata = 16'hBEEF;
    #1;
    chk("pw_ready", {31'b0, bus.c_ready}, 32'd1);
    chk("pw_no_wren_accept", {31'b0, bus.m_wren}, 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("pw_drain", {bus.m_wren, bus.m_addr, bus.m_din}, {1'b1, 14'h1ABC, 16'hBEEF});
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 13'h1ABC;
    #1;
    chk("pw_rd_ready", {31'b0, bus.c_ready}, 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("pw_rd_data", {bus.c_rvalid, bus.c_rdata}, {1'b1, 16'hBEEF});
  endtask

  task automatic test_starvation();
    for (int k = 0; k <= LIMIT; k++) begin
      @(negedge clk);
      bus.d_req = 1'b1; bus.d_addr = 13'(k);
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 13'h0010;
      #1;
      if (k < LIMIT)
        chk("starve_disp", {bus.d_gnt, bus.c_ready}, 32'b10);
      else
        chk("starve_forced_crd", {bus.d_gnt, bus.c_ready}, 32'b01);
    end
    @(negedge clk);
    bus.c_req = 1'b0;
    #1;
    chk("starve_disp_resume", {31'b0, bus.d_gnt}, 32'd1);
    chk("starve_crd_data", {bus.c_rvalid, bus.c_rdata}, {1'b1, 16'hA010});
    idle_inputs();
  endtask

  task automatic test_raw_ordering();
    int drain_cyc = -1;
    int grant_cyc = -1;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_addr = 13'h0020;
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 13'h0005; bus.c_wdata = 16'h1234;
    #1;
    chk("raw_wr_ready", {31'b0, bus.c_ready}, 32'd1);
    for (int cyc = 1; cyc < 20 && grant_cyc < 0; cyc++) begin
      @(negedge clk);
      bus.c_we = 1'b0;
      #1;
      if (bus.m_wren && bus.m_addr == 14'h0005 && bus.m_din == 16'h1234) drain_cyc = cyc;
      if (bus.c_ready) grant_cyc = cyc;
    end
    chk("raw_drain_cycle", 32'(drain_cyc), 32'd5);
    chk("raw_read_cycle", 32'(grant_cyc), 32'd10);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("raw_read_data", {bus.c_rvalid, bus.c_rdata}, {1'b1, 16'h1234});
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 13'h0100; bus.c_wdata = 16'h1111;
    #1;
    chk("b2b_ready0", {bus.c_ready, bus.m_wren}, 32'b10);
    @(negedge clk);
    bus.c_addr = 13'h0101; bus.c_wdata = 16'h2222;
    #1;
    chk("b2b_ready1", {31'b0, bus.c_ready}, 32'd1);
    chk("b2b_drain0", {bus.m_wren, bus.m_addr, bus.m_din}, {1'b1, 14'h0100, 16'h1111});
    @(negedge clk);
    idle_inputs();
    #1;
    chk("b2b_drain1", {bus.m_wren, bus.m_addr, bus.m_din}, {1'b1, 14'h0101, 16'h2222});
    @(negedge clk); #1;
    chk("b2b_quiet", {31'b0, bus.m_wren}, 32'd0);
  endtask

  task automatic test_async_reset();
    // Buffered write, reset lands before its drain: it must be discarded.
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 13'h0200; bus.c_wdata = 16'h5555;
    #1;
    chk("ar_wr_ready", {31'b0, bus.c_ready}, 32'd1);
    #2 resetn = 1'b0;
    bus.d_req = 1'b1; bus.c_we = 1'b0;
    @(negedge clk); #1;
    chk("ar_outputs_zero", {bus.d_gnt, bus.c_ready, bus.d_rvalid, bus.c_rvalid, bus.m_wren,
        bus.m_addr, bus.m_din}, 32'd0);
    idle_inputs();
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("ar_no_drain", {31'b0, bus.m_wren}, 32'd0);
    end
    // Read granted, reset asserted ahead of the returning edge: no rvalid.
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 13'h0040;
    #1;
    chk("ar_rd_ready", {31'b0, bus.c_ready}, 32'd1);
    #2 resetn = 1'b0;
    idle_inputs();
    @(negedge clk); #1;
    chk("ar_rvalid_in_reset", {31'b0, bus.c_rvalid}, 32'd0);
    resetn = 1'b1;
    @(negedge clk); #1;
    chk("ar_rvalid_after", {31'b0, bus.c_rvalid}, 32'd0);
    // Fresh behaviour: discarded write left RAM untouched; display works.
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_addr = 13'h0200;
    #1;
    chk("ar_post_rd_ready", {31'b0, bus.c_ready}, 32'd1);
    @(negedge clk);
    idle_inputs();
    bus.d_req = 1'b1; bus.d_addr = 13'h0003;
    #1;
    chk("ar_post_rd_data", {bus.c_rvalid, bus.c_rdata}, {1'b1, 16'hA200});
    chk("ar_post_dgnt", {31'b0, bus.d_gnt}, 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("ar_post_ddata", {bus.d_rvalid, bus.d_rdata}, {1'b1, 16'hA003});
  endtask

  // Randomized traffic against a slot-level reference: each cycle decide who
  // uses the RAM from the arbitration rules, keep a shadow memory, and
  // predict what the returning read must carry.
  logic [15:0] shadow [0:8191];

  task automatic test_random();
    bit          wb_pend = 0;
    logic [12:0] wb_a = '0;
    logic [15:0] wb_d = '0;
    int          disp_run = 0;
    int          ret_kind = 0;
    logic [15:0] ret_data = '0;
    bit          hold = 0;
    @(negedge clk);
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 8192; i++) shadow[i] = mem[i];
    for (int n = 0; n < 600; n++) begin
      bit cpu_side, cpu_turn, disp, drain, crd, wacc, rdy;
      logic [13:0] e_addr;
      @(negedge clk);
      bus.d_req  = ($urandom_range(0, 99) < 60);
      bus.d_addr = 13'($urandom_range(0, 15));
      if (!hold) begin
        bus.c_req   = ($urandom_range(0, 99) < 55);
        bus.c_we    = $urandom_range(0, 1);
        bus.c_addr  = 13'($urandom_range(0, 15));
        bus.c_wdata = 16'($urandom);
      end
      #1;
      cpu_side = wb_pend || (bus.c_req && !bus.c_we);
      cpu_turn = cpu_side && (disp_run >= LIMIT || !bus.d_req);
      disp     = bus.d_req && !cpu_turn;
      drain    = cpu_turn && wb_pend;
      crd      = cpu_turn && !wb_pend;
      wacc     = bus.c_req && bus.c_we && (!wb_pend || drain);
      rdy      = wacc || (bus.c_req && !bus.c_we && crd);
      e_addr   = disp ? {1'b0, bus.d_addr} : drain ? {1'b0, wb_a} : crd ? {1'b0, bus.c_addr} : 14'h0;
      chk("rnd_dgnt", {31'b0, bus.d_gnt}, {31'b0, disp});
      chk("rnd_cready", {31'b0, bus.c_ready}, {31'b0, rdy});
      chk("rnd_ram", {bus.m_wren, bus.m_addr, bus.m_din}, {drain, e_addr, drain ? wb_d : 16'h0});
      chk("rnd_dret", {bus.d_rvalid, bus.d_rdata}, {ret_kind == 1, ret_kind == 1 ? ret_data : 16'h0});
      chk("rnd_cret", {bus.c_rvalid, bus.c_rdata}, {ret_kind == 2, ret_kind == 2 ? ret_data : 16'h0});
      if (disp) begin ret_kind = 1; ret_data = shadow[bus.d_addr]; end
      else if (crd) begin ret_kind = 2; ret_data = shadow[bus.c_addr]; end
      else ret_kind = 0;
      if (drain) shadow[wb_a] = wb_d;
      if (wacc) begin wb_pend = 1; wb_a = bus.c_addr; wb_d = bus.c_wdata; end
      else if (drain) wb_pend = 0;
      if (drain || crd || !cpu_side) disp_run = 0;
      else if (disp && disp_run < LIMIT) disp_run++;
      hold = bus.c_req && !rdy;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_display_only();
    test_posted_write();
    test_starvation();
    test_raw_ordering();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
